register_status_table: RTL and testbench

Tracks, for each of the four architectural registers, which reservation station tag will produce its next value (0 = value already in register file). Sits upstream of the register file: drives reg1..reg4_status_table, which the register file uses to steer completing results. Updated by the dual-issue stage (new destination tags) and by completion broadcasts (adder/mult/fetch); provides source-operand tags to the issue stage.

---
 rtl/register_status_table.sv | 102 ++++++++++
 tb/tb_register_status_table.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_status_table.sv
// Register status table: per architectural register, the reservation-station tag that will
// produce its next value (0 = ready). Optional macro CDB_BYPASS_EN forwards same-cycle completions to source lookups.
module register_status_table #(
    parameter int TAG_W = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             iss1_valid,
    input  logic [IDX_W-1:0] iss1_dst,
    input  logic [TAG_W-1:0] iss1_tag,
    input  logic [IDX_W-1:0] iss1_src_a,
    input  logic [IDX_W-1:0] iss1_src_b,
    input  logic             iss2_valid,
    input  logic [IDX_W-1:0] iss2_dst,
    input  logic [TAG_W-1:0] iss2_tag,
    input  logic [IDX_W-1:0] iss2_src_a,
    input  logic [IDX_W-1:0] iss2_src_b,
    input  logic [TAG_W-1:0] add_done_tag,
    input  logic [TAG_W-1:0] mult_done_tag,
    input  logic [TAG_W-1:0] fetch_done_tag,
    output logic [TAG_W-1:0] reg1_status_table,
    output logic [TAG_W-1:0] reg2_status_table,
    output logic [TAG_W-1:0] reg3_status_table,
    output logic [TAG_W-1:0] reg4_status_table,
    output logic [TAG_W-1:0] iss1_qa,
    output logic [TAG_W-1:0] iss1_qb,
    output logic [TAG_W-1:0] iss2_qa,
    output logic [TAG_W-1:0] iss2_qb,
    output logic [2:0]       pending_cnt
);

    localparam int NREG = 1 << IDX_W;

    logic [TAG_W-1:0] entry_q [NREG];
    logic [TAG_W-1:0] entry_d [NREG];
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;

    function automatic logic done_match(input logic [TAG_W-1:0] tag);
        return (tag != '0) &&
               (tag == add_done_tag || tag == mult_done_tag || tag == fetch_done_tag);
    endfunction

    // Later assignments win: clear, then older issue, then younger issue (WAW).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            entry_d[i] = entry_q[i];
            if (done_match(entry_q[i]))
                entry_d[i] = '0;
            if (iss1_valid && iss1_dst == IDX_W'(i))
                entry_d[i] = iss1_tag;
            if (iss2_valid && iss2_dst == IDX_W'(i))
                entry_d[i] = iss2_tag;
            if (flush)
                entry_d[i] = '0;
            if (entry_d[i] != '0)
                cnt_d = cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                entry_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            for (int i = 0; i < NREG; i++)
                entry_q[i] <= entry_d[i];
            cnt_q <= cnt_d;
        end
    end

    function automatic logic [TAG_W-1:0] lookup(input logic [IDX_W-1:0] src);
`ifdef CDB_BYPASS_EN
        return done_match(entry_q[src]) ? '0 : entry_q[src];
`else
        return entry_q[src];
`endif
    endfunction

    // Instruction2 sees instruction1's destination before it reaches the table.
    function automatic logic [TAG_W-1:0] lookup2(input logic [IDX_W-1:0] src);
        return (iss1_valid && iss1_dst == src) ? iss1_tag : lookup(src);
    endfunction

    assign iss1_qa = lookup(iss1_src_a);
    assign iss1_qb = lookup(iss1_src_b);
    assign iss2_qa = lookup2(iss2_src_a);
    assign iss2_qb = lookup2(iss2_src_b);

    assign reg1_status_table = entry_q[0];
    assign reg2_status_table = entry_q[1];
    assign reg3_status_table = entry_q[2];
    assign reg4_status_table = entry_q[3];
    assign pending_cnt       = cnt_q;

endmodule

// File: tb/tb_register_status_table.sv
// Self-checking bench for register_status_table: directed vectors, a per-cycle model
// comparison on the falling edge, and literal checks pinning the test-plan scenarios.
module tb_register_status_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       iss1_valid, iss2_valid;
    logic [1:0] iss1_dst, iss1_src_a, iss1_src_b;
    logic [1:0] iss2_dst, iss2_src_a, iss2_src_b;
    logic [3:0] iss1_tag, iss2_tag;
    logic [3:0] add_done_tag, mult_done_tag, fetch_done_tag;
    logic [3:0] reg1_status_table, reg2_status_table, reg3_status_table, reg4_status_table;
    logic [3:0] iss1_qa, iss1_qb, iss2_qa, iss2_qb;
    logic [2:0] pending_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] model [4];

    register_status_table #(.TAG_W(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss1_valid(iss1_valid), .iss1_dst(iss1_dst), .iss1_tag(iss1_tag),
        .iss1_src_a(iss1_src_a), .iss1_src_b(iss1_src_b),
        .iss2_valid(iss2_valid), .iss2_dst(iss2_dst), .iss2_tag(iss2_tag),
        .iss2_src_a(iss2_src_a), .iss2_src_b(iss2_src_b),
        .add_done_tag(add_done_tag), .mult_done_tag(mult_done_tag),
        .fetch_done_tag(fetch_done_tag),
        .reg1_status_table(reg1_status_table), .reg2_status_table(reg2_status_table),
        .reg3_status_table(reg3_status_table), .reg4_status_table(reg4_status_table),
        .iss1_qa(iss1_qa), .iss1_qb(iss1_qb), .iss2_qa(iss2_qa), .iss2_qb(iss2_qb),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit completing(input logic [3:0] t);
        return t != 0 && (t == add_done_tag || t == mult_done_tag || t == fetch_done_tag);
    endfunction

    function automatic int exp_table_lookup(input logic [1:0] r);
`ifdef CDB_BYPASS_EN
        if (completing(model[r])) return 0;
`endif
        return int'(model[r]);
    endfunction

    function automatic int exp_bundle_lookup(input logic [1:0] r);
        if (iss1_valid && iss1_dst == r) return int'(iss1_tag);
        return exp_table_lookup(r);
    endfunction

    function automatic int exp_pending();
        int n = 0;
        foreach (model[r]) if (model[r] != 0) n++;
        return n;
    endfunction

    // Model: a register takes the youngest producer issued to it this cycle; with no new
    // producer it becomes ready if its producer completes, otherwise it keeps waiting.
    always @(posedge clk or posedge rst) begin
        for (int r = 0; r < 4; r++) begin
            if (rst || flush)                          model[r] <= 4'd0;
            else if (iss2_valid && iss2_dst == 2'(r))  model[r] <= iss2_tag;
            else if (iss1_valid && iss1_dst == 2'(r))  model[r] <= iss1_tag;
            else if (completing(model[r]))             model[r] <= 4'd0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model reg1", int'(reg1_status_table), int'(model[0]));
            check("model reg2", int'(reg2_status_table), int'(model[1]));
            check("model reg3", int'(reg3_status_table), int'(model[2]));
            check("model reg4", int'(reg4_status_table), int'(model[3]));
            check("model pending_cnt", int'(pending_cnt), exp_pending());
            check("model iss1_qa", int'(iss1_qa), exp_table_lookup(iss1_src_a));
            check("model iss1_qb", int'(iss1_qb), exp_table_lookup(iss1_src_b));
            check("model iss2_qa", int'(iss2_qa), exp_bundle_lookup(iss2_src_a));
            check("model iss2_qb", int'(iss2_qb), exp_bundle_lookup(iss2_src_b));
        end
    end

    task automatic idle();
        flush = 0;
        iss1_valid = 0; iss1_dst = 0; iss1_tag = 0; iss1_src_a = 0; iss1_src_b = 0;
        iss2_valid = 0; iss2_dst = 0; iss2_tag = 0; iss2_src_a = 0; iss2_src_b = 0;
        add_done_tag = 0; mult_done_tag = 0; fetch_done_tag = 0;
    endtask

    task automatic issue1(input logic [1:0] dst, input logic [3:0] tag);
        iss1_valid = 1; iss1_dst = dst; iss1_tag = tag;
    endtask

    task automatic issue2(input logic [1:0] dst, input logic [3:0] tag);
        iss2_valid = 1; iss2_dst = dst; iss2_tag = tag;
    endtask

    // Applies the current vector at the next rising edge, then returns to idle inputs.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_regs(input string name, input int r1, input int r2, input int r3,
                              input int r4, input int cnt);
        check({name, " reg1"}, int'(reg1_status_table), r1);
        check({name, " reg2"}, int'(reg2_status_table), r2);
        check({name, " reg3"}, int'(reg3_status_table), r3);
        check({name, " reg4"}, int'(reg4_status_table), r4);
        check({name, " pending_cnt"}, int'(pending_cnt), cnt);
    endtask

    initial begin
        idle();
        rst = 1;
        #12;
        check_regs("reset", reg1_status_table, 0, 0, 0, 0);
        check("reset reg1 literal", int'(reg1_status_table), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Dual issue to distinct registers.
        issue1(2'd1, 4'd1); issue2(2'd3, 4'd4);
        step();
        check_regs("issue", 0, 1, 0, 4, 2);

        // WAW in one bundle, then stale and matching completions.
        issue1(2'd0, 4'd2); issue2(2'd0, 4'd5);
        step();
        check_regs("waw", 5, 1, 0, 4, 3);
        add_done_tag = 4'd2;
        step();
        check_regs("stale done", 5, 1, 0, 4, 3);
        fetch_done_tag = 4'd5;
        step();
        check_regs("fetch done", 0, 1, 0, 4, 2);

        // Issue beats a same-cycle completion of the old producer.
        issue1(2'd1, 4'd3);
        step();
        check("setup r1=3", int'(reg2_status_table), 3);
        mult_done_tag = 4'd3; issue1(2'd1, 4'd6);
        step();
        check_regs("issue vs clear", 0, 6, 0, 4, 2);

        // Intra-bundle RAW bypass.
        issue1(2'd3, 4'd7);
        step();
        issue1(2'd2, 4'd1); iss1_src_a = 2'd2;
        iss2_src_a = 2'd2; iss2_src_b = 2'd3;
        #1;
        check("raw iss2_qa", int'(iss2_qa), 1);
        check("raw iss2_qb", int'(iss2_qb), 7);
        check("raw iss1_qa not bypassed", int'(iss1_qa), 0);
        step();
        check_regs("raw commit", 0, 6, 1, 7, 3);

        // Completion broadcast seen by a same-cycle lookup.
        issue1(2'd0, 4'd4);
        step();
        check("setup r0=4", int'(reg1_status_table), 4);
        mult_done_tag = 4'd4; iss1_src_a = 2'd0; iss1_src_b = 2'd3;
        issue1(2'd1, 4'd4); iss2_src_a = 2'd1;
        #1;
`ifdef CDB_BYPASS_EN
        check("cdb iss1_qa", int'(iss1_qa), 0);
`else
        check("cdb iss1_qa", int'(iss1_qa), 4);
`endif
        check("cdb iss1_qb untouched", int'(iss1_qb), 7);
        check("cdb iss2_qa bypass tag kept", int'(iss2_qa), 4);
        step();
        check_regs("cdb commit", 0, 4, 1, 7, 3);

        // Flush overrides issue and completion.
        flush = 1; issue1(2'd0, 4'd8); add_done_tag = 4'd1;
        step();
        check_regs("flush", 0, 0, 0, 0, 0);

        // Tag 0 issue means ready; one done tag clears several entries.
        issue1(2'd1, 4'd3);
        step();
        issue1(2'd1, 4'd0);
        step();
        check_regs("tag0 issue", 0, 0, 0, 0, 0);
        issue1(2'd0, 4'd5); issue2(2'd2, 4'd5);
        step();
        check_regs("dup tag", 5, 0, 5, 0, 2);
        add_done_tag = 4'd5;
        step();
        check_regs("multi clear", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run.
        issue1(2'd2, 4'd3);
        step();
        check("setup r2=3", int'(reg3_status_table), 3);
        #2;
        rst = 1;
        #1;
        check_regs("async reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        issue2(2'd3, 4'd8);
        step();
        check_regs("post reset", 0, 0, 0, 8, 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
